// File: rtl/unstripe_pkg.sv
// Shared defaults, selector state encoding and pointer-width helper for the unstripe merge stage.
package unstripe_pkg;

  localparam int DATA_WIDTH_DEF = 32;
  localparam int DEPTH_DEF      = 4;

  typedef enum logic {
    EXPECT0 = 1'b0,
    EXPECT1 = 1'b1
  } sel_t;

  function automatic int ptr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/unstripe_lane_fifo.sv
// Per-lane synchronous FIFO: a pushed word is visible at head one edge later.
// Caller gates push/pop; a push while full is only legal when paired with a pop.
module unstripe_lane_fifo
  import unstripe_pkg::*;
#(
  parameter int WIDTH = DATA_WIDTH_DEF,
  parameter int DEPTH = DEPTH_DEF,
  localparam int AW   = ptr_width(DEPTH),
  localparam int CW   = AW + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] head,
  output logic             empty,
  output logic             full,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;

  assign head  = mem[rd_ptr];
  assign empty = (count == '0);
  assign full  = (count == CW'(DEPTH));

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      count <= count + CW'(push) - CW'(pop);
    end
  end

endmodule

// File: rtl/unstripe.sv
// Merges lane0/lane1 back into one stream in strict alternating order; one edge minimum latency.
// No upstream backpressure: a word arriving at a full lane FIFO is dropped and flagged sticky.
module unstripe
  import unstripe_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int DEPTH      = DEPTH_DEF
) (
  input  logic                  clk_2f,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] lane0,
  input  logic                  valid0,
  input  logic [DATA_WIDTH-1:0] lane1,
  input  logic                  valid1,
  output logic [DATA_WIDTH-1:0] dataOut,
  output logic                  validOut,
  output logic                  overflowErr
);

  localparam int CW = ptr_width(DEPTH) + 1;

  sel_t                  sel;
  logic [DATA_WIDTH-1:0] head0, head1;
  logic                  empty0, empty1;
  logic                  full0, full1;
  logic [CW-1:0]         count0, count1;
  logic                  pop0, pop1, push0, push1;
  logic                  drop, realign;

  assign pop0  = (sel == EXPECT0) && !empty0;
  assign pop1  = (sel == EXPECT1) && !empty1;
  // A full FIFO still accepts a word on the edge its head leaves.
  assign push0 = valid0 && (!full0 || pop0);
  assign push1 = valid1 && (!full1 || pop1);
  assign drop  = (valid0 && !push0) || (valid1 && !push1);

  // With no arrivals, both FIFOs end empty iff each count equals its pop.
  assign realign = !valid0 && !valid1 &&
                   (count0 == CW'(pop0)) && (count1 == CW'(pop1));

  unstripe_lane_fifo #(.WIDTH(DATA_WIDTH), .DEPTH(DEPTH)) u_lane_fifo0 (
    .clk   (clk_2f),
    .reset (reset),
    .push  (push0),
    .pop   (pop0),
    .din   (lane0),
    .head  (head0),
    .empty (empty0),
    .full  (full0),
    .count (count0)
  );

  unstripe_lane_fifo #(.WIDTH(DATA_WIDTH), .DEPTH(DEPTH)) u_lane_fifo1 (
    .clk   (clk_2f),
    .reset (reset),
    .push  (push1),
    .pop   (pop1),
    .din   (lane1),
    .head  (head1),
    .empty (empty1),
    .full  (full1),
    .count (count1)
  );

  always_ff @(posedge clk_2f) begin
    if (reset) begin
      sel         <= EXPECT0;
      dataOut     <= '0;
      validOut    <= 1'b0;
      overflowErr <= 1'b0;
    end else begin
      if (pop0 || pop1) begin
        dataOut  <= pop0 ? head0 : head1;
        validOut <= 1'b1;
      end else begin
        validOut <= 1'b0;
      end

      if (realign) begin
        sel <= EXPECT0;
      end else if (pop0 || pop1) begin
        sel <= (sel == EXPECT0) ? EXPECT1 : EXPECT0;
      end

      if (drop) begin
        overflowErr <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_unstripe.sv
// Randomised and directed stimulus for unstripe, checked every cycle against a queue-based model.
module tb_unstripe;

  localparam int DW    = 32;
  localparam int DEPTH = 4;

  logic          clk_2f = 1'b0;
  logic          reset  = 1'b1;
  logic [DW-1:0] lane0  = '0;
  logic [DW-1:0] lane1  = '0;
  logic          valid0 = 1'b0;
  logic          valid1 = 1'b0;
  logic [DW-1:0] dataOut;
  logic          validOut;
  logic          overflowErr;

  unstripe #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .clk_2f      (clk_2f),
    .reset       (reset),
    .lane0       (lane0),
    .valid0      (valid0),
    .lane1       (lane1),
    .valid1      (valid1),
    .dataOut     (dataOut),
    .validOut    (validOut),
    .overflowErr (overflowErr)
  );

  always #5 clk_2f = ~clk_2f;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;
  int t0    = 0;

  logic [DW-1:0] log_d[$];
  int            log_c[$];
  logic [DW-1:0] exp_q[$];

  // Reference model: two word queues plus the expected-lane bit.
  logic [DW-1:0] m_q0[$];
  logic [DW-1:0] m_q1[$];
  bit            m_sel;
  logic [DW-1:0] m_dout;
  bit            m_vout;
  bit            m_err;
  bit            m_known = 1'b0;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, cyc);
    end
  endtask

  always @(posedge clk_2f) begin
    bit            r, v0, v1, popped;
    logic [DW-1:0] d0, d1;
    r  = reset;
    v0 = valid0;
    v1 = valid1;
    d0 = lane0;
    d1 = lane1;
    if (r) begin
      m_q0.delete();
      m_q1.delete();
      m_sel   = 1'b0;
      m_dout  = '0;
      m_vout  = 1'b0;
      m_err   = 1'b0;
      m_known = 1'b1;
    end else begin
      popped = 1'b0;
      if (!m_sel && m_q0.size() > 0) begin
        m_dout = m_q0.pop_front();
        popped = 1'b1;
      end else if (m_sel && m_q1.size() > 0) begin
        m_dout = m_q1.pop_front();
        popped = 1'b1;
      end
      m_vout = popped;
      if (v0) begin
        if (m_q0.size() < DEPTH) m_q0.push_back(d0);
        else m_err = 1'b1;
      end
      if (v1) begin
        if (m_q1.size() < DEPTH) m_q1.push_back(d1);
        else m_err = 1'b1;
      end
      if (popped) m_sel = !m_sel;
      if (!v0 && !v1 && m_q0.size() == 0 && m_q1.size() == 0) m_sel = 1'b0;
    end
    cyc++;
    #1;
    if (m_known) begin
      chk("validOut", validOut, m_vout);
      chk("overflowErr", overflowErr, m_err);
      chk("dataOut", dataOut, m_dout);
      if (validOut === 1'b1) begin
        log_d.push_back(dataOut);
        log_c.push_back(cyc);
      end
    end
  end

  task automatic drive(input bit v0, input logic [DW-1:0] d0, input bit v1, input logic [DW-1:0] d1);
    @(negedge clk_2f);
    reset  = 1'b0;
    valid0 = v0;
    lane0  = d0;
    valid1 = v1;
    lane1  = d1;
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, '0, 1'b0, '0);
  endtask

  task automatic do_reset();
    @(negedge clk_2f);
    reset  = 1'b1;
    valid0 = 1'b0;
    valid1 = 1'b0;
    t0     = cyc + 1;
    log_d.delete();
    log_c.delete();
  endtask

  task automatic chk_log(input string name);
    chk({name, " count"}, DW'(log_d.size()), DW'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < log_d.size(); i++) begin
      chk($sformatf("%s word %0d", name, i), log_d[i], exp_q[i]);
    end
  endtask

  initial begin
    // Aligned stream
    do_reset();
    drive(1'b1, 32'hA000_0000, 1'b0, '0);
    drive(1'b0, '0, 1'b1, 32'hB000_0000);
    drive(1'b1, 32'hA000_0001, 1'b0, '0);
    drive(1'b0, '0, 1'b1, 32'hB000_0001);
    idle(4);
    exp_q = '{32'hA000_0000, 32'hB000_0000, 32'hA000_0001, 32'hB000_0001};
    chk_log("aligned");
    for (int i = 0; i < 4 && i < log_c.size(); i++)
      chk($sformatf("aligned edge %0d", i), DW'(log_c[i]), DW'(t0 + 2 + i));

    // Lane1 arrives two edges ahead of lane0
    do_reset();
    drive(1'b0, '0, 1'b1, 32'hB0);
    idle(1);
    drive(1'b1, 32'hA0, 1'b0, '0);
    idle(4);
    exp_q = '{32'hA0, 32'hB0};
    chk_log("skew");
    if (log_c.size() == 2) begin
      chk("skew edge A0", DW'(log_c[0]), DW'(t0 + 4));
      chk("skew edge B0", DW'(log_c[1]), DW'(t0 + 5));
    end

    // Overflow on lane1
    do_reset();
    for (int i = 1; i <= 5; i++) drive(1'b0, '0, 1'b1, DW'(i));
    chk("ovf before drop", DW'(overflowErr), DW'(0));
    drive(1'b1, 32'd10, 1'b0, '0);
    chk("ovf after drop", DW'(overflowErr), DW'(1));
    drive(1'b1, 32'd11, 1'b0, '0);
    drive(1'b1, 32'd12, 1'b0, '0);
    drive(1'b1, 32'd13, 1'b0, '0);
    idle(12);
    exp_q = '{32'd10, 32'd1, 32'd11, 32'd2, 32'd12, 32'd3, 32'd13, 32'd4};
    chk_log("overflow");

    // Odd-length packet followed by a fresh packet
    do_reset();
    drive(1'b1, 32'hA0, 1'b0, '0);
    drive(1'b0, '0, 1'b1, 32'hB0);
    drive(1'b1, 32'hA1, 1'b0, '0);
    idle(2);
    drive(1'b1, 32'hC0, 1'b0, '0);
    drive(1'b0, '0, 1'b1, 32'hD0);
    idle(4);
    exp_q = '{32'hA0, 32'hB0, 32'hA1, 32'hC0, 32'hD0};
    chk_log("realign");
    if (log_c.size() == 5) chk("realign C0 edge", DW'(log_c[3]), DW'(t0 + 7));

    // Reset with words buffered and the error flag set
    for (int i = 0; i < 5; i++) drive(1'b0, '0, 1'b1, DW'(32'h20 + i));
    drive(1'b0, '0, 1'b0, '0);
    chk("pre-reset ovf", DW'(overflowErr), DW'(1));
    do_reset();
    drive(1'b1, 32'hE0, 1'b0, '0);
    chk("reset dataOut", dataOut, '0);
    chk("reset validOut", DW'(validOut), DW'(0));
    chk("reset ovf", DW'(overflowErr), DW'(0));
    drive(1'b0, '0, 1'b1, 32'hF0);
    idle(6);
    exp_q = '{32'hE0, 32'hF0};
    chk_log("post-reset");

    // Push and pop together on a full lane0 FIFO
    do_reset();
    drive(1'b1, 32'h50, 1'b0, '0);
    for (int i = 1; i <= 4; i++) drive(1'b1, DW'(32'h60 + i), 1'b0, '0);
    drive(1'b0, '0, 1'b1, 32'h51);
    idle(1);
    drive(1'b1, 32'h70, 1'b0, '0);
    for (int i = 1; i <= 4; i++) drive(1'b0, '0, 1'b1, DW'(32'h80 + i));
    chk("full push/pop ovf", DW'(overflowErr), DW'(0));
    idle(12);
    exp_q = '{32'h50, 32'h51, 32'h61, 32'h81, 32'h62, 32'h82,
              32'h63, 32'h83, 32'h64, 32'h84, 32'h70};
    chk_log("full push/pop");
    chk("full push/pop ovf end", DW'(overflowErr), DW'(0));

    // Randomised traffic with varying lane occupancy and occasional resets
    do_reset();
    for (int blk = 0; blk < 12; blk++) begin
      int p0, p1;
      p0 = 20 * $urandom_range(1, 5) - 10;
      p1 = 20 * $urandom_range(1, 5) - 10;
      for (int i = 0; i < 250; i++) begin
        if ($urandom_range(0, 199) == 0) begin
          do_reset();
        end else begin
          drive($urandom_range(0, 99) < p0, DW'($urandom), $urandom_range(0, 99) < p1, DW'($urandom));
        end
      end
    end
    idle(20);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/unstripe.md
# unstripe

Two-lane merge stage directly downstream of the striping block. It consumes the lane0/lane1 word streams produced by the striper and re-serialises them into a single 32-bit stream in the original alternating order (lane0, lane1, lane0, …) in the clk_2f domain. Per-lane FIFOs absorb inter-lane skew up to DEPTH words and preserve strict ordering. A sticky error flag reports lane overflow.

## Interface

Parameters:
- DATA_WIDTH, 32: word width of lanes and output.
- DEPTH, 4: words per lane FIFO. Must be a power of two and ≥ 2.

Ports:
- clk_2f  input  1  2f clock; the only clock. All state updates on its rising edge.
- reset  input  1  synchronous, active-high reset.
- lane0  input  DATA_WIDTH  lane 0 word (even-position words).
- valid0  input  1  lane0 carries a new word this cycle.
- lane1  input  DATA_WIDTH  lane 1 word (odd-position words).
- valid1  input  1  lane1 carries a new word this cycle.
- dataOut  output  DATA_WIDTH  merged word, registered.
- validOut  output  1  dataOut carries a new word this cycle, registered.
- overflowErr  output  1  sticky: a lane word was dropped on a full FIFO.

## Operation

- Each rising edge with validN=1 is exactly one new word on laneN. Held values across cycles count as repeated words.
- Lane FIFOs:
  - validN=1 and FIFO N not full: laneN is pushed.
  - validN=1 and FIFO N full: the word is dropped, overflowErr←1, and FIFO contents are unchanged.
  - Push and pop on the same FIFO in the same edge is legal: count is unchanged, and a full FIFO being popped accepts the push.
- Selector `sel` (1 bit, 0=lane0 expected) is a 2-state FSM: EXPECT0 and EXPECT1.
  - If FIFO[sel] holds a word, pop its head: dataOut←head, validOut←1, sel←~sel.
  - If FIFO[sel] is empty: validOut←0, dataOut holds its last value, and sel is unchanged, even if the other FIFO holds data. Order is never violated.
- Realignment at end of packet: if, after this edge's push/pop, both FIFO counts are 0 and valid0=valid1=0 were sampled this edge, then sel←0, overriding the toggle. An odd-length packet therefore does not misalign the next packet.
- No pop ever bypasses a FIFO. A word pushed on edge k is eligible to pop no earlier than edge k+1.
- Reset, including mid-operation: both FIFOs are emptied, sel=0, dataOut=0, validOut=0, overflowErr=0. Lane inputs sampled during reset are discarded.

## Timing

- Minimum latency: word sampled on edge k appears on dataOut/validOut after edge k+1.
- Steady state with both lanes alternating (striper output) gives one output word per clk_2f cycle, with validOut continuously high.
- Ordering is lane0[0], lane1[0], lane0[1], lane1[1], …, independent of arrival skew ≤ DEPTH words.
- overflowErr is set on the edge the drop occurs and visible the following cycle. It clears only on reset.
- Pointer arithmetic is log2(DEPTH) bits, wrapping modulo DEPTH. Count is log2(DEPTH)+1 bits, with full at count==DEPTH.

## Structure

- Shared package holds:
  - default DATA_WIDTH and DEPTH;
  - state encoding constants EXPECT0=1'b0 and EXPECT1=1'b1;
  - the pointer-width helper (clog2).
- One sub-module, lane_fifo: synchronous FIFO with push, pop, head, empty, full and count, instantiated twice. The top contains the FSM, the output register and the error flag.

## Test plan

- Aligned stream: after reset, lane0=A0 on edge 1, lane1=B0 on edge 2, lane0=A1 on edge 3, lane1=B1 on edge 4 -> dataOut A0, B0, A1, B1 after edges 2, 3, 4, 5; validOut high for exactly those 4 cycles; sel=0 after edge 5.
- Skew: lane1=B0 on edge 1, lane0=A0 on edge 3 -> validOut=0 after edges 1–3; A0 after edge 4; B0 after edge 5.
- Overflow: DEPTH=4, valid1 held high for 5 edges with lane1=1..5 while lane0 idle -> overflowErr=1 after edge 5. Then lane0 pushes 10,11,12,13 -> output 10,1,11,2,12,3,13,4; word 5 is never output.
- Odd packet realign: A0, B0, A1, then idle 2 cycles, then C0 on lane0 and D0 on lane1 -> output A0, B0, A1, C0, D0; C0 is not stalled waiting for lane1.
- Reset mid-stream: 3 words buffered and reset asserted for 1 edge -> dataOut=0, validOut=0, overflowErr=0 next cycle. New stream E0/F0 is output as E0, F0 with no stale words.
- Simultaneous push/pop on full FIFO: lane0 full (4 words), sel=0, valid0=1 -> pop head and accept push; count stays 4 and overflowErr stays 0.
